// File: rtl/comp_stats_if.sv
// Operand/result handshake bundle for comp_stats.
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; a source holds its payload stable while
// valid is 1 and ready is 0, and ready never depends on the same cycle's valid
// or payload.
// slave  : the comparator block (consumes operands, produces results).
// master : the environment (upstream producer and downstream consumer).
interface comp_stats_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_code;
  logic [15:0] res_max;

  modport slave (
    input  in_valid, in1, in2, res_ready,
    output in_ready, res_valid, res_code, res_max
  );

  modport master (
    output in_valid, in1, in2, res_ready,
    input  in_ready, res_valid, res_code, res_max
  );
endinterface

// File: rtl/comp_stats.sv
// comp_stats: unsigned 16-bit comparator with a one-entry registered output
// holder and saturating per-outcome event counters.
// Optional feature: define COMP_STATS_RUNMAX_EN to build the running-maximum
// register; without it run_max is tied to zero.
// dbg_state is 1 while the output holder is FULL, 0 while EMPTY.
module comp_stats #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  comp_stats_if.slave      bus,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [15:0]      run_max,
  output logic             dbg_state
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] CODE_EQ = 2'b00;
  localparam logic [1:0] CODE_GT = 2'b01;
  localparam logic [1:0] CODE_LT = 2'b10;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        drain;
  logic [1:0]  code_new;
  logic [15:0] pair_max;

  // The holder can take a new pair when empty, or when its current result
  // leaves in the same cycle; this depends only on state and res_ready.
  assign bus.in_ready  = (state_q == EMPTY) || bus.res_ready;
  assign bus.res_valid = (state_q == FULL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = bus.res_valid && bus.res_ready;
  assign dbg_state     = state_q;

  // Classify the incoming pair and pick its larger operand (in1 on a tie).
  always_comb begin
    code_new = CODE_EQ;
    pair_max = bus.in1;
    if (bus.in1 > bus.in2) begin
      code_new = CODE_GT;
    end else if (bus.in1 < bus.in2) begin
      code_new = CODE_LT;
      pair_max = bus.in2;
    end
  end

  // Holder state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Holder next state: fill on accept, empty when drained without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Result payload: loaded on every accept, otherwise held stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_code <= CODE_EQ;
      bus.res_max  <= 16'h0000;
    end else if (accept) begin
      bus.res_code <= code_new;
      bus.res_max  <= pair_max;
    end
  end

  // Saturating outcome counters; clear wins over a concurrent accept.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_eq <= '0;
      cnt_gt <= '0;
      cnt_lt <= '0;
    end else if (accept) begin
      case (code_new)
        CODE_GT: if (cnt_gt != '1) cnt_gt <= cnt_gt + CNT_W'(1);
        CODE_LT: if (cnt_lt != '1) cnt_lt <= cnt_lt + CNT_W'(1);
        default: if (cnt_eq != '1) cnt_eq <= cnt_eq + CNT_W'(1);
      endcase
    end
  end

`ifdef COMP_STATS_RUNMAX_EN
  // Running maximum over all accepted operands since reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run_max <= 16'h0000;
    end else if (accept && (pair_max > run_max)) begin
      run_max <= pair_max;
    end
  end
`else
  assign run_max = 16'h0000;
`endif

endmodule

// File: tb/tb_comp_stats.sv
// Bench for comp_stats: directed scenarios followed by randomized traffic.
// Expected results are queued at the accept edge and retired by a monitor
// on each output transfer; counters and running maximum come from a
// reference model updated with plain integer arithmetic.
module tb_comp_stats;
  localparam int CNT_W   = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             clear;
  logic [CNT_W-1:0] cnt_eq;
  logic [CNT_W-1:0] cnt_gt;
  logic [CNT_W-1:0] cnt_lt;
  logic [15:0]      run_max;
  logic             dbg_state;

  comp_stats_if ifc ();

  comp_stats #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .clear     (clear),
    .cnt_eq    (cnt_eq),
    .cnt_gt    (cnt_gt),
    .cnt_lt    (cnt_lt),
    .run_max   (run_max),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];          // {code, max} of results not yet drained
  int          m_eq, m_gt, m_lt;  // reference counters
  int          m_run;             // reference running maximum
  int          tests;
  int          fails;
  bit          chk_en;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs at the falling edge, predict the handshake,
  // then apply the specified behaviour to the model at the rising edge.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic rr, input logic clr, input logic r);
    bit      acc;
    bit      rdy;
    int      code;
    int      mx;
    @(negedge clk);
    ifc.in_valid  = v;
    ifc.in1       = a;
    ifc.in2       = b;
    ifc.res_ready = rr;
    clear         = clr;
    rst           = r;
    #1;
    rdy = (exp_q.size() == 0) || rr;
    acc = v && rdy;
    if (chk_en) chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, rdy});
    code = (a == b) ? 0 : ((a > b) ? 1 : 2);
    mx   = (a >= b) ? int'(a) : int'(b);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_eq = 0; m_gt = 0; m_lt = 0; m_run = 0;
    end else begin
      if (clr) begin
        m_eq = 0; m_gt = 0; m_lt = 0; m_run = 0;
      end else if (acc) begin
        if (code == 0) m_eq = sat_inc(m_eq);
        else if (code == 1) m_gt = sat_inc(m_gt);
        else m_lt = sat_inc(m_lt);
`ifdef COMP_STATS_RUNMAX_EN
        if (mx > m_run) m_run = mx;
`endif
      end
      if (acc) exp_q.push_back({code[1:0], mx[15:0]});
    end
  endtask

  function automatic logic [15:0] rand_op(input int mode, input logic [15:0] other);
    case (mode)
      0: return other;
      1: return 16'($urandom_range(0, 15));
      2: return ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- monitor: retire on output transfer ----------------
  always @(posedge clk) begin
    if (chk_en && !rst && ifc.res_valid === 1'b1 && ifc.res_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL drain: result transferred with nothing expected");
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- monitor: compare presented outputs ----------------
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("res_valid", {31'd0, ifc.res_valid}, {31'd0, exp_q.size() != 0});
      chk("dbg_state", {31'd0, dbg_state}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("res_code", {30'd0, ifc.res_code}, {30'd0, exp_q[0][17:16]});
        chk("res_max", {16'd0, ifc.res_max}, {16'd0, exp_q[0][15:0]});
      end
      chk("cnt_eq", 32'(cnt_eq), 32'(m_eq));
      chk("cnt_gt", 32'(cnt_gt), 32'(m_gt));
      chk("cnt_lt", 32'(cnt_lt), 32'(m_lt));
      chk("run_max", {16'd0, run_max}, 32'(m_run));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          mode;
    logic [15:0] a;
    logic [15:0] b;
    tests = 0; fails = 0; chk_en = 0;
    m_eq = 0; m_gt = 0; m_lt = 0; m_run = 0;
    ifc.in_valid = 0; ifc.in1 = 0; ifc.in2 = 0; ifc.res_ready = 0;
    clear = 0; rst = 1;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_en = 1;
    #2;
    chk("reset_res_code", {30'd0, ifc.res_code}, 32'd0);
    chk("reset_res_max", {16'd0, ifc.res_max}, 32'd0);

    // Equal pair straight after reset.
    step(1, 16'hA925, 16'hA925, 1, 0, 0);
    #2;
    chk("eq_first_valid", {31'd0, ifc.res_valid}, 32'd1);
    chk("eq_first_code", {30'd0, ifc.res_code}, 32'd0);
    chk("eq_first_max", {16'd0, ifc.res_max}, 32'hA925);
    chk("eq_first_cnt", 32'(cnt_eq), 32'd1);

    // Back-to-back gt / lt / eq.
    step(0, 0, 0, 1, 0, 1);
    step(1, 5, 3, 1, 0, 0);
    step(1, 3, 5, 1, 0, 0);
    step(1, 7, 7, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    #2;
    chk("b2b_cnt_gt", 32'(cnt_gt), 32'd1);
    chk("b2b_cnt_lt", 32'(cnt_lt), 32'd1);
    chk("b2b_cnt_eq", 32'(cnt_eq), 32'd1);
`ifdef COMP_STATS_RUNMAX_EN
    chk("b2b_run_max", {16'd0, run_max}, 32'd7);
`else
    chk("b2b_run_max", {16'd0, run_max}, 32'd0);
`endif

    // Backpressure then release with a new pair in the same cycle.
    step(1, 2, 4, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0);
    #2;
    chk("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
    chk("bp_held_code", {30'd0, ifc.res_code}, 32'd2);
    step(1, 9, 1, 1, 0, 0);
    #2;
    chk("bp_release_code", {30'd0, ifc.res_code}, 32'd1);
    chk("bp_release_valid", {31'd0, ifc.res_valid}, 32'd1);
    step(0, 0, 0, 1, 0, 0);

    // Saturation of cnt_eq.
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 16'(i * 3), 16'(i * 3), 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    #2;
    chk("sat_cnt_eq", 32'(cnt_eq), 32'(CNT_SAT));

    // Clear concurrent with an accepted pair.
    step(1, 16'h1234, 16'h0002, 1, 0, 0);
    step(1, 16'hFFFF, 16'h0000, 1, 1, 0);
    #2;
    chk("clr_cnt_gt", 32'(cnt_gt), 32'd0);
    chk("clr_cnt_eq", 32'(cnt_eq), 32'd0);
    chk("clr_run_max", {16'd0, run_max}, 32'd0);
    chk("clr_res_max", {16'd0, ifc.res_max}, 32'hFFFF);
    chk("clr_res_code", {30'd0, ifc.res_code}, 32'd1);

    // Reset while FULL and stalled.
    step(1, 1, 2, 0, 0, 0);
    step(1, 3, 3, 0, 0, 1);
    #2;
    chk("rst_full_valid", {31'd0, ifc.res_valid}, 32'd0);
    chk("rst_full_cnt_lt", 32'(cnt_lt), 32'd0);
    chk("rst_full_in_ready", {31'd0, ifc.in_ready}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      mode = $urandom_range(0, 3);
      a = rand_op($urandom_range(1, 3), 16'h0000);
      b = rand_op(mode, a);
      step($urandom_range(0, 99) < 75, a, b,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 1);
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
